// File: rtl/iob_soc_opencryptolinux_pbus_arbiter.sv
// Round-robin arbiter for the shared peripheral IOb bus. One transaction is in flight at a time.
// Grant takes 1 cycle. Writes complete on ready. Reads complete on rvalid. Losing masters keep avalid high until served.
module iob_soc_opencryptolinux_pbus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                           clk_i,
  input  logic                           cke_i,
  input  logic                           arst_i,
  input  logic [N_MASTERS-1:0]           m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]    m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb_i,
  output logic [N_MASTERS-1:0]           m_ready_o,
  output logic [N_MASTERS-1:0]           m_rvalid_o,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic                           s_avalid_o,
  output logic [ADDR_W-1:0]              s_addr_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  output logic [DATA_W/8-1:0]            s_wstrb_o,
  input  logic                           s_ready_i,
  input  logic                           s_rvalid_i,
  input  logic [DATA_W-1:0]              s_rdata_i,
  output logic [$clog2(N_MASTERS)-1:0]   grant_o,
  output logic                           busy_o
);

  localparam int GW = $clog2(N_MASTERS);
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_R} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [GW:0]     cand;
  logic [GW-1:0]   pick_idx;
  logic            pick_vld;
  logic [GW-1:0]   grant_inc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [SW-1:0]     sel_wstrb;

  assign sel_addr  = m_addr_i[grant_q*ADDR_W +: ADDR_W];
  assign sel_wdata = m_wdata_i[grant_q*DATA_W +: DATA_W];
  assign sel_wstrb = m_wstrb_i[grant_q*SW +: SW];
  assign grant_inc = (grant_q == GW'(N_MASTERS-1)) ? '0 : grant_q + 1'b1;

  // First requester found when scanning upward from rr_ptr, wrapping at N_MASTERS
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(N_MASTERS)) cand = cand - (GW+1)'(N_MASTERS);
      if (!pick_vld && m_avalid_i[cand[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A withdrawn request gives up the slot without advancing the pointer
        if (!m_avalid_i[grant_q]) begin
          state_d = IDLE;
        end else if (s_ready_i) begin
          if (|sel_wstrb) begin
            state_d  = IDLE;
            rr_ptr_d = grant_inc;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (s_rvalid_i) begin
          state_d  = IDLE;
          rr_ptr_d = grant_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else if (cke_i) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    m_ready_o  = '0;
    m_rvalid_o = '0;
    s_avalid_o = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    case (state_q)
      ACCESS: begin
        s_avalid_o          = m_avalid_i[grant_q];
        s_addr_o            = sel_addr;
        s_wdata_o           = sel_wdata;
        s_wstrb_o           = sel_wstrb;
        m_ready_o[grant_q]  = s_ready_i;
      end
      WAIT_R:  m_rvalid_o[grant_q] = s_rvalid_i;
      default: ;
    endcase
  end

  assign m_rdata_o = s_rdata_i;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_iob_soc_opencryptolinux_pbus_arbiter.sv
// Bench for the peripheral bus arbiter: directed vector table, hand-written reset/clock-enable
// sequences, then random traffic checked against a transaction-level reference model.
module tb_iob_soc_opencryptolinux_pbus_arbiter;

  localparam int N = 2;

  logic          clk_i = 1'b0;
  logic          cke_i;
  logic          arst_i;
  logic [N-1:0]  m_avalid_i;
  logic [N*32-1:0] m_addr_i;
  logic [N*32-1:0] m_wdata_i;
  logic [N*4-1:0]  m_wstrb_i;
  logic [N-1:0]  m_ready_o;
  logic [N-1:0]  m_rvalid_o;
  logic [31:0]   m_rdata_o;
  logic          s_avalid_o;
  logic [31:0]   s_addr_o;
  logic [31:0]   s_wdata_o;
  logic [3:0]    s_wstrb_o;
  logic          s_ready_i;
  logic          s_rvalid_i;
  logic [31:0]   s_rdata_i;
  logic [0:0]    grant_o;
  logic          busy_o;

  int tests = 0;
  int fails = 0;

  iob_soc_opencryptolinux_pbus_arbiter #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .m_avalid_i(m_avalid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_ready_o(m_ready_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  av;
    logic [3:0]  w0;
    logic [3:0]  w1;
    logic        sr;
    logic        rv;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rv;
    logic        e_sav;
    logic        e_gnt;
    logic        e_busy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic [1:0] av, input logic [3:0] w0, input logic [3:0] w1,
                              input logic sr, input logic rv, input logic [1:0] e_rdy,
                              input logic [1:0] e_rv, input logic e_sav, input logic e_gnt,
                              input logic e_busy, input logic [31:0] e_addr);
    vec_t v;
    v.av = av; v.w0 = w0; v.w1 = w1; v.sr = sr; v.rv = rv;
    v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_sav = e_sav; v.e_gnt = e_gnt;
    v.e_busy = e_busy; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    arst_i = 1'b1;
    cke_i = 1'b1;
    m_avalid_i = '0;
    m_wstrb_i = '0;
    s_ready_i = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i = '0;
    tick();
    tick();
    arst_i = 1'b0;
  endtask

  // Reference model state: who owns the bus, whether read data is outstanding,
  // where the next round-robin scan begins, and the last granted master.
  int  owner;
  bit  awaiting;
  int  first;
  int  last;

  logic [31:0] r_addr[N];
  logic [31:0] r_wdata[N];
  logic [3:0]  r_wstrb[N];

  initial begin
    logic [1:0]  e_rdy, e_rv;
    logic        e_sav;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_ws;
    bit          found;
    int          c;

    m_addr_i = '0;
    m_wdata_i = '0;

    vecs[0]  = mk(2'b10, 4'h0, 4'hF, 1, 0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
    vecs[1]  = mk(2'b10, 4'h0, 4'hF, 1, 0, 2'b10, 2'b00, 1, 1, 1, 32'h10);
    vecs[2]  = mk(2'b00, 4'h0, 4'hF, 0, 0, 2'b00, 2'b00, 0, 1, 0, 32'h0);
    vecs[3]  = mk(2'b01, 4'h0, 4'hF, 0, 0, 2'b00, 2'b00, 0, 1, 0, 32'h0);
    vecs[4]  = mk(2'b01, 4'h0, 4'hF, 1, 0, 2'b01, 2'b00, 1, 0, 1, 32'h4);
    vecs[5]  = mk(2'b10, 4'h0, 4'hF, 1, 0, 2'b00, 2'b00, 0, 0, 1, 32'h0);
    vecs[6]  = mk(2'b10, 4'h0, 4'hF, 1, 0, 2'b00, 2'b00, 0, 0, 1, 32'h0);
    vecs[7]  = mk(2'b10, 4'h0, 4'hF, 1, 1, 2'b00, 2'b01, 0, 0, 1, 32'h0);
    vecs[8]  = mk(2'b10, 4'h0, 4'hF, 1, 0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
    vecs[9]  = mk(2'b10, 4'h0, 4'hF, 1, 0, 2'b10, 2'b00, 1, 1, 1, 32'h10);
    vecs[10] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b00, 2'b00, 0, 1, 0, 32'h0);
    vecs[11] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b01, 2'b00, 1, 0, 1, 32'h4);
    vecs[12] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
    vecs[13] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b10, 2'b00, 1, 1, 1, 32'h10);
    vecs[14] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b00, 2'b00, 0, 1, 0, 32'h0);
    vecs[15] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b01, 2'b00, 1, 0, 1, 32'h4);
    vecs[16] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
    vecs[17] = mk(2'b11, 4'hF, 4'hF, 1, 0, 2'b10, 2'b00, 1, 1, 1, 32'h10);
    vecs[18] = mk(2'b11, 4'hF, 4'hF, 0, 0, 2'b00, 2'b00, 0, 1, 0, 32'h0);
    vecs[19] = mk(2'b10, 4'hF, 4'hF, 0, 0, 2'b00, 2'b00, 0, 0, 1, 32'h4);
    vecs[20] = mk(2'b10, 4'hF, 4'hF, 0, 0, 2'b00, 2'b00, 0, 0, 0, 32'h0);
    vecs[21] = mk(2'b10, 4'hF, 4'hF, 1, 0, 2'b10, 2'b00, 1, 1, 1, 32'h10);

    // Reset held with both masters requesting: every output quiet
    do_reset();
    arst_i = 1'b1;
    m_avalid_i = 2'b11;
    m_addr_i = {32'h10, 32'h4};
    m_wdata_i = {32'hDEADBEEF, 32'h0};
    m_wstrb_i = 8'hFF;
    s_ready_i = 1'b1;
    s_rvalid_i = 1'b1;
    tick();
    tick();
    #2;
    chk("reset_ctrl", {m_ready_o, m_rvalid_o, s_avalid_o, grant_o, busy_o, s_wstrb_o}, 64'h0);
    chk("reset_addr_rdata", {s_addr_o, m_rdata_o}, 64'h0);
    chk("reset_wdata", {32'h0, s_wdata_o}, 64'h0);
    arst_i = 1'b0;
    tick();
    #2;
    chk("release_grant", {63'h0, grant_o}, 64'h0);
    chk("release_busy", {63'h0, busy_o}, 64'h1);

    // Directed vector table
    do_reset();
    m_addr_i = {32'h10, 32'h4};
    m_wdata_i = {32'hDEADBEEF, 32'h0};
    s_rdata_i = 32'h12345678;
    for (int i = 0; i < 22; i++) begin
      m_avalid_i = vecs[i].av;
      m_wstrb_i = {vecs[i].w1, vecs[i].w0};
      s_ready_i = vecs[i].sr;
      s_rvalid_i = vecs[i].rv;
      #3;
      chk($sformatf("vec%0d_ready", i), {62'h0, m_ready_o}, {62'h0, vecs[i].e_rdy});
      chk($sformatf("vec%0d_rvalid", i), {62'h0, m_rvalid_o}, {62'h0, vecs[i].e_rv});
      chk($sformatf("vec%0d_savalid", i), {63'h0, s_avalid_o}, {63'h0, vecs[i].e_sav});
      chk($sformatf("vec%0d_grant", i), {63'h0, grant_o}, {63'h0, vecs[i].e_gnt});
      chk($sformatf("vec%0d_busy", i), {63'h0, busy_o}, {63'h0, vecs[i].e_busy});
      chk($sformatf("vec%0d_addr", i), {32'h0, s_addr_o}, {32'h0, vecs[i].e_addr});
      chk($sformatf("vec%0d_rdata", i), {32'h0, m_rdata_o}, 64'h12345678);
      if (vecs[i].e_addr == 32'h10 && vecs[i].e_sav)
        chk($sformatf("vec%0d_wdata", i), {32'h0, s_wdata_o}, 64'hDEADBEEF);
      tick();
    end

    // Reset while a read is outstanding: the late rvalid must be dropped
    do_reset();
    m_avalid_i = 2'b01;
    m_wstrb_i = 8'h00;
    s_ready_i = 1'b1;
    tick();
    tick();
    m_avalid_i = 2'b00;
    #2;
    chk("midread_busy", {63'h0, busy_o}, 64'h1);
    arst_i = 1'b1;
    s_rvalid_i = 1'b1;
    #1;
    chk("midread_in_reset", {60'h0, m_rvalid_o, busy_o, s_avalid_o}, 64'h0);
    tick();
    arst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk($sformatf("midread_post_rv%0d", i), {62'h0, m_rvalid_o}, 64'h0);
      chk($sformatf("midread_post_busy%0d", i), {63'h0, busy_o}, 64'h0);
      tick();
    end
    s_rvalid_i = 1'b0;
    s_ready_i = 1'b0;
    m_avalid_i = 2'b10;
    m_wstrb_i = 8'hF0;
    tick();
    #2;
    chk("midread_next_grant", {62'h0, grant_o, busy_o}, 64'h3);

    // Clock enable low freezes the arbiter in IDLE
    do_reset();
    cke_i = 1'b0;
    m_avalid_i = 2'b01;
    tick();
    tick();
    #2;
    chk("cke_frozen_busy", {63'h0, busy_o}, 64'h0);
    cke_i = 1'b1;
    tick();
    #2;
    chk("cke_resume", {62'h0, grant_o, busy_o}, 64'h1);

    // Random traffic against the transaction-level model
    do_reset();
    owner = -1;
    awaiting = 0;
    first = 0;
    last = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        r_addr[k] = $urandom;
        r_wdata[k] = $urandom;
        r_wstrb[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        m_addr_i[k*32 +: 32] = r_addr[k];
        m_wdata_i[k*32 +: 32] = r_wdata[k];
        m_wstrb_i[k*4 +: 4] = r_wstrb[k];
      end
      m_avalid_i = 2'($urandom_range(0, 3));
      s_ready_i = ($urandom_range(0, 3) != 0);
      s_rvalid_i = ($urandom_range(0, 2) == 0);
      s_rdata_i = $urandom;
      cke_i = ($urandom_range(0, 7) != 0);
      #3;
      e_rdy = '0; e_rv = '0; e_sav = 1'b0; e_addr = '0; e_wd = '0; e_ws = '0;
      if (owner >= 0 && !awaiting) begin
        e_sav = m_avalid_i[owner];
        e_addr = r_addr[owner];
        e_wd = r_wdata[owner];
        e_ws = r_wstrb[owner];
        e_rdy[owner] = s_ready_i;
      end
      if (owner >= 0 && awaiting) e_rv[owner] = s_rvalid_i;
      chk("rnd_ready", {62'h0, m_ready_o}, {62'h0, e_rdy});
      chk("rnd_rvalid", {62'h0, m_rvalid_o}, {62'h0, e_rv});
      chk("rnd_savalid", {63'h0, s_avalid_o}, {63'h0, e_sav});
      chk("rnd_addr", {32'h0, s_addr_o}, {32'h0, e_addr});
      chk("rnd_wdata", {32'h0, s_wdata_o}, {32'h0, e_wd});
      chk("rnd_wstrb", {60'h0, s_wstrb_o}, {60'h0, e_ws});
      chk("rnd_grant", {63'h0, grant_o}, 64'(last));
      chk("rnd_busy", {63'h0, busy_o}, {63'h0, owner >= 0});
      chk("rnd_rdata", {32'h0, m_rdata_o}, {32'h0, s_rdata_i});
      if (cke_i) begin
        if (owner < 0) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            c = (first + k) % N;
            if (!found && m_avalid_i[c]) begin
              found = 1;
              owner = c;
              last = c;
            end
          end
        end else if (!awaiting) begin
          if (!m_avalid_i[owner]) owner = -1;
          else if (s_ready_i) begin
            if (r_wstrb[owner] != 4'h0) begin
              first = (owner + 1) % N;
              owner = -1;
            end else awaiting = 1;
          end
        end else if (s_rvalid_i) begin
          first = (owner + 1) % N;
          owner = -1;
          awaiting = 0;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
